// File: rtl/ternary_stream_loader.sv
// Program loader: assembles 9-trit words from a serial trit stream and writes
// them into instruction memory at consecutive balanced-ternary addresses.
module ternary_stream_loader #(
   parameter int unsigned MAX_WORDS = 243
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [1:0]  in_trit,
   output logic        in_ready,
   output logic        mem_write,
   output logic [17:0] mem_addr,
   output logic [17:0] mem_write_data,
   output logic        loading,
   output logic        done,
   output logic        error,
   output logic [17:0] word_count
);

   localparam int unsigned TRITS = 9;
   localparam int unsigned WW    = 2 * TRITS;
   localparam int          MAX_I = int'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_IDLE, S_HEADER, S_BODY, S_WRITE, S_DONE, S_ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    idx_q;
   logic [WW-1:0] word_q;
   logic [WW-1:0] n_q;
   logic [WW-1:0] word_ins_c;
   logic [WW-1:0] count_inc_c;
   logic          beat_c, trit_bad_c, last_trit_c;
   logic          in_ready_d, mem_write_d, loading_d, done_d, error_d;
   int            hdr_val_c;

   // Balanced-ternary word to signed integer.
   function automatic int tern_to_int(input logic [WW-1:0] w);
      int v;
      v = 0;
      for (int k = TRITS - 1; k >= 0; k--) begin
         v = v * 3;
         if (w[2*k +: 2] == 2'b01)      v = v + 1;
         else if (w[2*k +: 2] == 2'b10) v = v - 1;
      end
      return v;
   endfunction

   // Balanced-ternary +1 with carry rippling upward from trit 0.
   function automatic logic [WW-1:0] tern_inc(input logic [WW-1:0] w);
      logic [WW-1:0] r;
      logic          carry;
      r     = w;
      carry = 1'b1;
      for (int k = 0; k < TRITS; k++) begin
         if (carry) begin
            case (w[2*k +: 2])
               2'b10:   begin r[2*k +: 2] = 2'b00; carry = 1'b0; end
               2'b00:   begin r[2*k +: 2] = 2'b01; carry = 1'b0; end
               2'b01:   r[2*k +: 2] = 2'b10;
               default: carry = 1'b0;
            endcase
         end
      end
      return r;
   endfunction

   assign beat_c      = in_valid && in_ready;
   assign trit_bad_c  = (in_trit == 2'b11);
   assign last_trit_c = (idx_q == 4'(TRITS - 1));
   assign count_inc_c = tern_inc(word_count);
   assign hdr_val_c   = tern_to_int(word_ins_c);

   // Word register with the incoming trit placed at the current index.
   always_comb begin
      word_ins_c = word_q;
      for (int k = 0; k < TRITS; k++) begin
         if (idx_q == 4'(k)) word_ins_c[2*k +: 2] = in_trit;
      end
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_HEADER;
         S_HEADER: begin
            if (beat_c) begin
               if (trit_bad_c)       state_d = S_ERROR;
               else if (last_trit_c) state_d = (hdr_val_c >= 1 && hdr_val_c <= MAX_I)
                                               ? S_BODY : S_ERROR;
            end
         end
         S_BODY: begin
            if (beat_c) begin
               if (trit_bad_c)       state_d = S_ERROR;
               else if (last_trit_c) state_d = S_WRITE;
            end
         end
         S_WRITE:  state_d = (count_inc_c == n_q) ? S_DONE : S_BODY;
         S_DONE:   state_d = S_IDLE;
         S_ERROR:  if (start) state_d = S_HEADER;
         default:  state_d = S_IDLE;
      endcase
   end

   // Control outputs decoded from the upcoming state so they register cleanly.
   always_comb begin
      in_ready_d  = (state_d == S_HEADER) || (state_d == S_BODY);
      mem_write_d = (state_d == S_WRITE);
      loading_d   = (state_d == S_HEADER) || (state_d == S_BODY) || (state_d == S_WRITE);
      done_d      = (state_d == S_DONE);
      error_d     = (state_d == S_ERROR);
   end

   // Registered control outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         in_ready  <= 1'b0;
         mem_write <= 1'b0;
         loading   <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         in_ready  <= in_ready_d;
         mem_write <= mem_write_d;
         loading   <= loading_d;
         done      <= done_d;
         error     <= error_d;
      end
   end

   // Trit assembly, header capture, write data and address/count advance.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idx_q          <= '0;
         word_q         <= '0;
         n_q            <= '0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         word_count     <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_ERROR: begin
               if (start) begin
                  idx_q      <= '0;
                  word_q     <= '0;
                  mem_addr   <= '0;
                  word_count <= '0;
               end
            end
            S_HEADER, S_BODY: begin
               if (beat_c && !trit_bad_c) begin
                  if (last_trit_c) begin
                     idx_q  <= '0;
                     word_q <= '0;
                     if (state_q == S_HEADER) n_q            <= word_ins_c;
                     else                     mem_write_data <= word_ins_c;
                  end else begin
                     idx_q  <= idx_q + 4'd1;
                     word_q <= word_ins_c;
                  end
               end
            end
            S_WRITE: begin
               mem_addr   <= tern_inc(mem_addr);
               word_count <= count_inc_c;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ternary_stream_loader.sv
// Scoreboard bench for ternary_stream_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares every mem_write.
module tb_ternary_stream_loader;
   localparam int MAXW = 243;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [1:0]  in_trit = 2'b00;
   logic        in_ready, mem_write, loading, done, error;
   logic [17:0] mem_addr, mem_write_data, word_count;

   int          total = 0;
   int          bad = 0;
   logic [35:0] exp_q[$];
   logic [35:0] mon_e;
   bit          start_noise = 1'b0;
   bit          tog = 1'b0;

   ternary_stream_loader #(.MAX_WORDS(MAXW)) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .in_valid(in_valid), .in_trit(in_trit), .in_ready(in_ready),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .loading(loading), .done(done), .error(error), .word_count(word_count)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Integer to 9-trit balanced-ternary encoding by repeated division.
   function automatic logic [17:0] enc(input int v);
      logic [17:0] w;
      int r;
      w = '0;
      for (int k = 0; k < 9; k++) begin
         r = ((v % 3) + 3) % 3;
         if (r == 0)      begin w[2*k +: 2] = 2'b00; v = v / 3; end
         else if (r == 1) begin w[2*k +: 2] = 2'b01; v = (v - 1) / 3; end
         else             begin w[2*k +: 2] = 2'b10; v = (v + 1) / 3; end
      end
      return w;
   endfunction

   // Scoreboard monitor.
   always @(negedge clock) begin
      if (reset_n === 1'b1 && mem_write === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_write_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", 36'(mem_addr), 36'(mon_e[35:18]));
            check("write_data", 36'(mem_write_data), 36'(mon_e[17:0]));
         end
      end
   end

   // mode 0: always valid, 1: valid on alternate cycles, 2: random valid.
   task automatic send_trit(input logic [1:0] t, input int mode);
      bit acc;
      int guard;
      guard = 0;
      do begin
         in_trit = t;
         if (mode == 0)      in_valid = 1'b1;
         else if (mode == 1) begin in_valid = tog; tog = ~tog; end
         else                in_valid = 1'($urandom_range(0, 1));
         start = start_noise && ($urandom_range(0, 7) == 0);
         acc = in_valid && in_ready;
         @(posedge clock);
         #1;
         guard++;
      end while (!acc && guard < 100);
      in_valid = 1'b0;
      start = 1'b0;
      if (!acc) check("trit_accept_timeout", 36'(0), 36'(1));
   endtask

   task automatic send_word(input logic [17:0] w, input int mode);
      for (int k = 0; k < 9; k++) send_trit(w[2*k +: 2], mode);
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      check("start_in_ready", 36'(in_ready), 36'(1));
      check("start_loading", 36'(loading), 36'(1));
   endtask

   task automatic finish_done(input logic [17:0] cnt);
      @(posedge clock);
      #1;
      check("done_pulse", 36'(done), 36'(1));
      check("done_word_count", 36'(word_count), 36'(cnt));
      check("done_mem_addr", 36'(mem_addr), 36'(cnt));
      check("done_error", 36'(error), 36'(0));
      check("done_loading", 36'(loading), 36'(0));
      @(posedge clock);
      #1;
      check("done_one_cycle", 36'(done), 36'(0));
      check("sb_drained", 36'(exp_q.size()), 36'(0));
   endtask

   task automatic run_load(input int n, input int mode);
      logic [17:0] w;
      start_pulse();
      send_word(enc(n), mode);
      for (int i = 0; i < n; i++) begin
         w = enc(int'($urandom_range(0, 19682)) - 9841);
         send_word(w, mode);
         exp_q.push_back({enc(i), w});
      end
      finish_done(enc(n));
   endtask

   task automatic basic_load(input int mode);
      start_pulse();
      send_word({14'b0, 2'b01, 2'b10}, mode);
      send_word({12'b0, 2'b01, 2'b10, 2'b10}, mode);
      exp_q.push_back({18'h00000, 18'h0001A});
      send_word({14'b0, 2'b10, 2'b10}, mode);
      exp_q.push_back({18'h00001, 18'h0000A});
      finish_done(18'h00006);
   endtask

   initial begin
      int bad_n[3];
      logic [17:0] w;
      bad_n[0] = 0; bad_n[1] = -1; bad_n[2] = MAXW + 1;

      repeat (2) @(posedge clock);
      #1;
      check("rst_in_ready", 36'(in_ready), 36'(0));
      check("rst_mem_write", 36'(mem_write), 36'(0));
      check("rst_loading", 36'(loading), 36'(0));
      check("rst_done", 36'(done), 36'(0));
      check("rst_error", 36'(error), 36'(0));
      check("rst_buses", {mem_addr, mem_write_data}, 36'(0));
      check("rst_word_count", 36'(word_count), 36'(0));
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check("idle_no_ready", 36'(in_ready), 36'(0));

      basic_load(0);
      basic_load(1);

      // Out-of-range headers land in ERROR and ignore further data.
      for (int b = 0; b < 3; b++) begin
         start_pulse();
         send_word(enc(bad_n[b]), 0);
         check("badhdr_error", 36'(error), 36'(1));
         check("badhdr_in_ready", 36'(in_ready), 36'(0));
         check("badhdr_loading", 36'(loading), 36'(0));
         in_valid = 1'b1;
         repeat (3) @(posedge clock);
         #1;
         in_valid = 1'b0;
         check("badhdr_hold", {34'(0), error, in_ready}, 36'b10);
      end
      start_pulse();
      check("restart_clears_error", 36'(error), 36'(0));
      send_word(enc(1), 0);
      w = enc(-77);
      send_word(w, 0);
      exp_q.push_back({enc(0), w});
      finish_done(enc(1));

      // Invalid trit inside body word 2.
      start_pulse();
      send_word(enc(3), 0);
      w = enc(1234);
      send_word(w, 0);
      exp_q.push_back({enc(0), w});
      for (int k = 0; k < 4; k++) send_trit(2'b01, 0);
      send_trit(2'b11, 0);
      check("badtrit_error", 36'(error), 36'(1));
      check("badtrit_no_write", 36'(mem_write), 36'(0));
      repeat (3) @(posedge clock);
      #1;
      check("badtrit_word1_written", 36'(exp_q.size()), 36'(0));

      // Address carry sequence and maximum length.
      run_load(5, 0);
      run_load(MAXW, 0);

      // Randomized loads with stalls and ignored start pulses.
      start_noise = 1'b1;
      for (int r = 0; r < 6; r++) run_load(int'($urandom_range(1, 4)), 2);
      start_noise = 1'b0;

      // Asynchronous reset during the 4th trit of word 1.
      start_pulse();
      send_word(enc(2), 0);
      for (int k = 0; k < 3; k++) send_trit(2'b01, 0);
      in_valid = 1'b1;
      in_trit = 2'b10;
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_in_ready", 36'(in_ready), 36'(0));
      check("arst_loading", 36'(loading), 36'(0));
      check("arst_ctrl", {32'(0), mem_write, done, error, 1'b0}, 36'(0));
      check("arst_wdata", 36'(mem_write_data), 36'(0));
      check("arst_count", {mem_addr, word_count}, 36'(0));
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         in_trit = 2'($urandom_range(0, 2));
         @(posedge clock);
         #1;
         if (c == 4 || c == 9) check("post_rst_idle", {34'(0), in_ready, loading}, 36'(0));
      end
      in_valid = 1'b0;
      check("final_sb_drained", 36'(exp_q.size()), 36'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
